intr_ack_ctrl: RTL and testbench

CPU-side interrupt controller that terminates the IO subsystem's `intr`/`inta` handshake. It synchronises the IO interrupt request and waits for an instruction boundary with interrupts enabled. It then redirects the CPU to the ISR vector, saves the return PC in `epc`, and drives the `inta` acknowledge pulse that makes the IO module drop `intr`. It sits between the IO module and the MIPS control unit.

---
 rtl/intr_ack_ctrl_pkg.sv | 23 ++
 rtl/intr_ack_ctrl_sync.sv | 36 +++
 rtl/intr_ack_ctrl.sv | 126 ++++++++++++
 tb/tb_intr_ack_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ack_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// intr_ack_ctrl_pkg
// Shared definitions for the CPU-side interrupt acknowledge controller:
// the FSM state encoding, the default ISR entry address and the legal
// range of the inta pulse width.
// ----------------------------------------------------------------------------
package intr_ack_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_TAKE    = 3'd1;
   localparam state_t ST_ACK     = 3'd2;
   localparam state_t ST_DROP    = 3'd3;
   localparam state_t ST_SERVICE = 3'd4;

   localparam logic [31:0] ISR_VECTOR_DEFAULT = 32'h0000_03FC;

   localparam int INTA_CYCLES_MIN = 1;
   localparam int INTA_CYCLES_MAX = 15;
   localparam int INTA_CNT_W      = 4;

endpackage

// File: rtl/intr_ack_ctrl_sync.sv
// ----------------------------------------------------------------------------
// intr_sync
// Generic N-flop synchroniser for a single asynchronous level input.
// Reusable for any IO-side input that must be brought into the clk domain.
//   clk   : destination clock
//   rst   : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output, STAGES clock edges of latency
// ----------------------------------------------------------------------------
module intr_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/intr_ack_ctrl.sv
// ----------------------------------------------------------------------------
// intr_ack_ctrl
// Terminates the IO subsystem's intr/inta handshake on the CPU side. A
// synchronised interrupt request is taken at an instruction boundary while
// interrupts are enabled: the CPU is redirected to the ISR vector, the return
// PC is saved in epc, and inta is pulsed so the IO module drops intr.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   intr       : level interrupt request from IO (asynchronous)
//   int_en     : status-register interrupt enable
//   instr_done : one-cycle pulse at each instruction boundary
//   reti       : one-cycle pulse on return-from-interrupt
//   pc_in      : next sequential PC, valid with instr_done
//   inta       : interrupt acknowledge to IO, INTA_CYCLES wide
//   int_take   : one-cycle pulse, control unit loads vector into PC
//   vector     : constant ISR entry address
//   epc        : saved return address
//   in_service : high from take until reti
// ----------------------------------------------------------------------------
module intr_ack_ctrl
   import intr_ack_ctrl_pkg::*;
#(
   parameter logic [31:0] ISR_VECTOR  = ISR_VECTOR_DEFAULT,
   parameter int          INTA_CYCLES = 2,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        intr,
   input  logic        int_en,
   input  logic        instr_done,
   input  logic        reti,
   input  logic [31:0] pc_in,
   output logic        inta,
   output logic        int_take,
   output logic [31:0] vector,
   output logic [31:0] epc,
   output logic        in_service
);

   // Out-of-range widths are clamped so the counter never wraps.
   localparam int INTA_CLAMPED = (INTA_CYCLES < INTA_CYCLES_MIN) ? INTA_CYCLES_MIN :
                                 (INTA_CYCLES > INTA_CYCLES_MAX) ? INTA_CYCLES_MAX :
                                 INTA_CYCLES;
   localparam logic [INTA_CNT_W-1:0] INTA_LOAD = INTA_CNT_W'(INTA_CLAMPED - 1);

   state_t                state_q, state_d;
   logic [INTA_CNT_W-1:0] cnt_q, cnt_d;
   logic                  inta_q, inta_d;
   logic                  int_take_q, int_take_d;
   logic                  in_service_q, in_service_d;
   logic [31:0]           epc_q, epc_d;

   logic intr_s;
   logic take_req;

   intr_sync #(
      .STAGES (SYNC_STAGES)
   ) u_intr_sync (
      .clk (clk),
      .rst (rst),
      .d   (intr),
      .q   (intr_s)
   );

   assign take_req = intr_s & int_en & instr_done;

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         inta_q       <= 1'b0;
         int_take_q   <= 1'b0;
         in_service_q <= 1'b0;
         epc_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         inta_q       <= inta_d;
         int_take_q   <= int_take_d;
         in_service_q <= in_service_d;
         epc_q        <= epc_d;
      end
   end

   // Next state. Interrupt inputs are only looked at in IDLE, so no nesting;
   // reti only matters in SERVICE, which also gives it priority over a
   // coincident instr_done there.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (take_req)     state_d = ST_TAKE;
         ST_TAKE:                      state_d = ST_ACK;
         ST_ACK:     if (cnt_q == '0)  state_d = ST_DROP;
         ST_DROP:    if (!intr_s)      state_d = ST_SERVICE;
         ST_SERVICE: if (reti)         state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in
   // the same cycle the FSM enters the corresponding state.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == ST_ACK) begin
         cnt_d = (state_q != ST_ACK) ? INTA_LOAD : (cnt_q - 1'b1);
      end

      epc_d = epc_q;
      if ((state_q == ST_IDLE) && take_req) begin
         epc_d = pc_in;
      end

      int_take_d   = (state_d == ST_TAKE);
      inta_d       = (state_d == ST_ACK);
      in_service_d = (state_d != ST_IDLE);
   end

   assign inta       = inta_q;
   assign int_take   = int_take_q;
   assign in_service = in_service_q;
   assign epc        = epc_q;
   assign vector     = ISR_VECTOR;

endmodule

// File: tb/tb_intr_ack_ctrl.sv
// ----------------------------------------------------------------------------
// tb_intr_ack_ctrl
// Directed scenarios followed by a randomized run, every cycle compared
// against a phase-level reference model of the interrupt handshake.
// ----------------------------------------------------------------------------
module tb_intr_ack_ctrl;

   localparam logic [31:0] VEC    = 32'h0000_03FC;
   localparam int          INTA_N = 2;
   localparam int          SYNC_N = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        intr = 1'b0;
   logic        int_en = 1'b0;
   logic        instr_done = 1'b0;
   logic        reti = 1'b0;
   logic [31:0] pc_in = '0;
   logic        inta;
   logic        int_take;
   logic [31:0] vector;
   logic [31:0] epc;
   logic        in_service;

   int total = 0;
   int bad   = 0;

   // Reference model: the handshake as a sequence of phases.
   logic [SYNC_N-1:0] m_pipe;
   bit                m_busy;      // between take and reti
   bit                m_take;      // take pulse cycle
   int                m_ack_left;  // remaining inta cycles
   bit                m_wait_low;  // waiting for IO to release intr
   logic [31:0]       m_epc;

   int n_take;
   int n_inta;
   bit seen;

   intr_ack_ctrl #(
      .ISR_VECTOR  (VEC),
      .INTA_CYCLES (INTA_N),
      .SYNC_STAGES (SYNC_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .intr       (intr),
      .int_en     (int_en),
      .instr_done (instr_done),
      .reti       (reti),
      .pc_in      (pc_in),
      .inta       (inta),
      .int_take   (int_take),
      .vector     (vector),
      .epc        (epc),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pipe     = '0;
      m_busy     = 1'b0;
      m_take     = 1'b0;
      m_ack_left = 0;
      m_wait_low = 1'b0;
      m_epc      = '0;
   endtask

   task automatic model_edge();
      bit s;
      s      = m_pipe[SYNC_N-1];
      m_pipe = {m_pipe[SYNC_N-2:0], intr};
      if (!m_busy) begin
         if (s && int_en && instr_done) begin
            m_busy = 1'b1;
            m_take = 1'b1;
            m_epc  = pc_in;
         end
      end else if (m_take) begin
         m_take     = 1'b0;
         m_ack_left = INTA_N;
      end else if (m_ack_left > 0) begin
         m_ack_left--;
         if (m_ack_left == 0) m_wait_low = 1'b1;
      end else if (m_wait_low) begin
         if (!s) m_wait_low = 1'b0;
      end else if (reti) begin
         m_busy = 1'b0;
      end
   endtask

   // One clock: advance the model on the edge, compare just after it.
   task automatic step();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_edge();
      #1;
      check("int_take",   {31'b0, int_take},   {31'b0, m_take});
      check("inta",       {31'b0, inta},       {31'b0, (m_ack_left > 0)});
      check("in_service", {31'b0, in_service}, {31'b0, m_busy});
      check("epc",        epc,                 m_epc);
      check("vector",     vector,              VEC);
      if (int_take) n_take++;
      if (inta)     n_inta++;
   endtask

   task automatic pulse_done(input logic [31:0] pc);
      instr_done = 1'b1;
      pc_in      = pc;
      step();
      instr_done = 1'b0;
      pc_in      = $urandom;
   endtask

   task automatic pulse_reti();
      reti = 1'b1;
      step();
      reti = 1'b0;
   endtask

   initial begin
      model_reset();

      // Reset held: toggle every input, outputs stay at reset values.
      for (int i = 0; i < 8; i++) begin
         intr       = $urandom_range(0, 1);
         int_en     = $urandom_range(0, 1);
         instr_done = $urandom_range(0, 1);
         reti       = $urandom_range(0, 1);
         pc_in      = $urandom;
         step();
      end
      check("rst_inta", {31'b0, inta}, 32'd0);
      check("rst_epc",  epc,           32'd0);
      intr = 0; int_en = 0; instr_done = 0; reti = 0; pc_in = 0;
      step();
      rst = 1'b1;
      step();

      // Basic take.
      int_en = 1'b1;
      intr   = 1'b1;
      step();
      step();
      pulse_done(32'h0000_0040);
      check("basic_take", {31'b0, int_take}, 32'd1);
      check("basic_epc",  epc,               32'h0000_0040);
      n_take = 0; n_inta = 0;
      for (int i = 0; i < 6; i++) step();
      check("basic_inta_width", n_inta, INTA_N);
      check("basic_one_take",   n_take, 0);
      check("basic_in_service", {31'b0, in_service}, 32'd1);
      intr = 1'b0;
      for (int i = 0; i < 4; i++) step();
      pulse_reti();
      check("basic_reti_clears", {31'b0, in_service}, 32'd0);

      // Masked: 20 boundaries with int_en low, then enable.
      int_en = 1'b0;
      intr   = 1'b1;
      step(); step();
      n_take = 0; n_inta = 0;
      for (int i = 0; i < 20; i++) begin
         pulse_done($urandom);
         step();
      end
      check("masked_no_take", n_take, 0);
      check("masked_no_inta", n_inta, 0);
      int_en = 1'b1;
      pulse_done(32'h0000_0100);
      check("unmask_take", {31'b0, int_take}, 32'd1);
      check("unmask_epc",  epc,               32'h0000_0100);

      // Slow drop: intr stays high 10 cycles after inta falls.
      step(); step(); step();
      check("slow_inta_low", {31'b0, inta}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         reti = (i == 5);
         step();
      end
      reti = 1'b0;
      check("slow_reti_ignored", {31'b0, in_service}, 32'd1);
      intr = 1'b0;
      step(); step();
      pulse_reti();   // still DROP on this edge
      check("slow_reti_early", {31'b0, in_service}, 32'd1);
      pulse_reti();   // SERVICE reached SYNC_N+1 edges after intr fell
      check("slow_reti_taken", {31'b0, in_service}, 32'd0);

      // Re-arm during SERVICE.
      intr = 1'b1;
      step(); step();
      pulse_done(32'h0000_0200);
      intr = 1'b0;
      for (int i = 0; i < 6; i++) step();
      intr = 1'b1;
      n_take = 0; n_inta = 0;
      for (int i = 0; i < 5; i++) begin
         pulse_done($urandom);
         step();
      end
      check("rearm_no_take", n_take, 0);
      check("rearm_no_inta", n_inta, 0);
      check("rearm_epc_held", epc, 32'h0000_0200);
      pulse_reti();
      pulse_done(32'h0000_0300);
      check("rearm_take", {31'b0, int_take}, 32'd1);
      check("rearm_epc",  epc,               32'h0000_0300);

      // Reset mid-ACK.
      step();
      check("midack_inta_high", {31'b0, inta}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("midack_inta_async", {31'b0, inta},       32'd0);
      check("midack_svc_async",  {31'b0, in_service}, 32'd0);
      model_reset();
      step(); step();
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         pulse_done(32'h0000_0500 + i);
         if (int_take) seen = 1'b1;
      end
      check("midack_retake", {31'b0, seen}, 32'd1);
      intr = 1'b0;
      for (int i = 0; i < 6; i++) step();
      pulse_reti();

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) intr = ~intr;
         int_en     = ($urandom_range(0, 3) != 0);
         instr_done = ($urandom_range(0, 2) == 0);
         reti       = ($urandom_range(0, 5) == 0);
         pc_in      = $urandom;
         rst        = ($urandom_range(0, 499) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
